// File: rtl/spi_shifter.sv
// SPI master bit engine: generates SCLK/MOSI, samples MISO and raises SPIF on completion.
// Optional SPI_SHIFTER_MISO_SYNC_EN inserts a two-flop MISO synchronizer (tick period must be >= 4 cycles).
`timescale 1ns/1ps

module spi_shifter #(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ena_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] tx_i,
    output logic [DATA_W-1:0] rx_o,
    output logic              busy_o,
    output logic              irq_o,
    input  logic              ack_i,
    input  logic              cpol_i,
    input  logic              dord_i,
    input  logic              cpha_i,
    output logic              sclk_o,
    input  logic              miso_i,
    output logic              mosi_en_o,
    output logic              mosi_o
);

    localparam int CNT_W = $clog2(2 * DATA_W);
    localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(2 * DATA_W - 1);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [DATA_W-1:0]   tx_sh_reg, tx_sh_next;
    logic [DATA_W-1:0]   rx_sh_reg, rx_sh_next;
    logic [DATA_W-1:0]   rx_reg, rx_next;
    logic                irq_reg, irq_next;
    logic                sclk_reg, sclk_next;
    logic                cpol_m_reg, cpol_m_next;
    logic                cpha_m_reg, cpha_m_next;
    logic                dord_m_reg, dord_m_next;

    logic                miso_smp;
    logic [DATA_W-1:0]   tx_left, tx_right;
    logic [DATA_W-1:0]   rx_left, rx_right;

`ifdef SPI_SHIFTER_MISO_SYNC_EN
    logic miso_s1_reg, miso_s2_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            miso_s1_reg <= 1'b0;
            miso_s2_reg <= 1'b0;
        end else begin
            miso_s1_reg <= miso_i;
            miso_s2_reg <= miso_s1_reg;
        end
    end

    assign miso_smp = miso_s2_reg;
`else
    assign miso_smp = miso_i;
`endif

    // Both shift directions are built up front; the latched bit order picks one.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_shift
            if (gi == 0) begin : g_lsb
                assign tx_left[gi] = 1'b0;
                assign rx_left[gi] = miso_smp;
            end else begin : g_lsb_n
                assign tx_left[gi] = tx_sh_reg[gi-1];
                assign rx_left[gi] = rx_sh_reg[gi-1];
            end
            if (gi == DATA_W - 1) begin : g_msb
                assign tx_right[gi] = 1'b0;
                assign rx_right[gi] = miso_smp;
            end else begin : g_msb_n
                assign tx_right[gi] = tx_sh_reg[gi+1];
                assign rx_right[gi] = rx_sh_reg[gi+1];
            end
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            tx_sh_reg  <= '0;
            rx_sh_reg  <= '0;
            rx_reg     <= '0;
            irq_reg    <= 1'b0;
            sclk_reg   <= 1'b0;
            cpol_m_reg <= 1'b0;
            cpha_m_reg <= 1'b0;
            dord_m_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            tx_sh_reg  <= tx_sh_next;
            rx_sh_reg  <= rx_sh_next;
            rx_reg     <= rx_next;
            irq_reg    <= irq_next;
            sclk_reg   <= sclk_next;
            cpol_m_reg <= cpol_m_next;
            cpha_m_reg <= cpha_m_next;
            dord_m_reg <= dord_m_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        tx_sh_next  = tx_sh_reg;
        rx_sh_next  = rx_sh_reg;
        rx_next     = rx_reg;
        sclk_next   = sclk_reg;
        cpol_m_next = cpol_m_reg;
        cpha_m_next = cpha_m_reg;
        dord_m_next = dord_m_reg;
        // Acknowledge first so a completion in the same cycle overrides it.
        irq_next    = irq_reg & ~ack_i;

        case (state_reg)
            IDLE: begin
                sclk_next = cpol_i;
                if (start_i) begin
                    state_next  = XFER;
                    cnt_next    = '0;
                    tx_sh_next  = tx_i;
                    rx_sh_next  = '0;
                    cpol_m_next = cpol_i;
                    cpha_m_next = cpha_i;
                    dord_m_next = dord_i;
                end
            end
            XFER: begin
                if (ena_i) begin
                    sclk_next = ~sclk_reg;
                    cnt_next  = cnt_reg + CNT_W'(1);
                    // cnt_reg[0]==0 marks a leading edge; sampling happens on the edge matching CPHA.
                    if (cnt_reg[0] == cpha_m_reg) begin
                        rx_sh_next = dord_m_reg ? rx_right : rx_left;
                    end else if (cpha_m_reg ? (cnt_reg != '0) : (cnt_reg != LAST_EDGE)) begin
                        tx_sh_next = dord_m_reg ? tx_right : tx_left;
                    end
                    if (cnt_reg == LAST_EDGE) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                        sclk_next  = cpol_m_reg;
                        rx_next    = rx_sh_next;
                        irq_next   = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign rx_o      = rx_reg;
    assign busy_o    = (state_reg == XFER);
    assign mosi_en_o = (state_reg == XFER);
    assign irq_o     = irq_reg;
    assign sclk_o    = sclk_reg;
    assign mosi_o    = dord_m_reg ? tx_sh_reg[0] : tx_sh_reg[DATA_W-1];

endmodule

// File: tb/tb_spi_shifter.sv
// Directed bench for spi_shifter: SPI modes, bit orders, restart/ack/reset corner cases.
`timescale 1ns/1ps

module tb_spi_shifter;

    logic       clk = 1'b0;
    logic       rst, ena, start, ack, cpol, dord, cpha, miso_drv, loop_en;
    logic [7:0] tx;
    logic [7:0] rx;
    logic       busy, irq, sclk, mosi_en, mosi, miso;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    assign miso = loop_en ? mosi : miso_drv;

    spi_shifter #(.DATA_W(8)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .ena_i     (ena),
        .start_i   (start),
        .tx_i      (tx),
        .rx_o      (rx),
        .busy_o    (busy),
        .irq_o     (irq),
        .ack_i     (ack),
        .cpol_i    (cpol),
        .dord_i    (dord),
        .cpha_i    (cpha),
        .sclk_o    (sclk),
        .miso_i    (miso),
        .mosi_en_o (mosi_en),
        .mosi_o    (mosi)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // exp_seq lists the bits presented on MOSI at the slave sampling edges, first bit in bit 7.
    task automatic run_xfer(input string name, input logic [7:0] tx_w, input logic cp,
                            input logic cph, input logic dor, input int period,
                            input logic loop, input logic [7:0] miso_w,
                            input logic [7:0] exp_seq, input logic [7:0] exp_rx,
                            input int restart_at, input int cpol_flip_at, input logic ack_on_done);
        logic [7:0] seq;
        int         busy_cnt;
        int         sclk_err;
        logic       exp_sclk;
        int         k;
        seq      = '0;
        busy_cnt = 0;
        sclk_err = 0;
        cpol     = cp;
        cpha     = cph;
        dord     = dor;
        loop_en  = loop;
        tx       = tx_w;
        ack      = 1'b0;
        tick();
        tick();
        check({name, " idle_sclk"}, sclk, cp);
        start = 1'b1;
        ena   = 1'b1;
        tick();
        start = 1'b0;
        ena   = 1'b0;
        exp_sclk = cp;
        if (busy) busy_cnt++;
        if (sclk !== exp_sclk) sclk_err++;
        for (int n = 0; n < 16; n++) begin
            for (int c = 0; c < period; c++) begin
                if (c == period - 1) begin
                    ena = 1'b1;
                    if ((n % 2) == int'(cph)) begin
                        k = n / 2;
                        if (!loop) miso_drv = dor ? miso_w[k] : miso_w[7-k];
                        seq[7-k] = mosi;
                    end
                    if (n == restart_at) begin
                        start = 1'b1;
                        tx    = 8'hFF;
                    end
                    if (n == cpol_flip_at) cpol = ~cpol;
                    if (n == 15 && ack_on_done) ack = 1'b1;
                end
                tick();
                if (ena) exp_sclk = ~exp_sclk;
                start = 1'b0;
                ena   = 1'b0;
                ack   = 1'b0;
                if (busy) busy_cnt++;
                if (sclk !== exp_sclk) sclk_err++;
            end
        end
        check({name, " mosi_seq"}, seq, exp_seq);
        check({name, " rx"}, rx, exp_rx);
        check({name, " busy_cycles"}, busy_cnt, 16 * period);
        check({name, " sclk_wave"}, sclk_err, 0);
        check({name, " irq_done"}, irq, 1'b1);
        check({name, " mosi_en_done"}, mosi_en, 1'b0);
        $display("xfer %s tx=%02h mosi_seq=%02h rx=%02h busy_cycles=%0d", name, tx_w, seq, rx, busy_cnt);
    endtask

    initial begin
        rst = 1'b1; ena = 1'b0; start = 1'b0; ack = 1'b0;
        cpol = 1'b0; dord = 1'b0; cpha = 1'b0;
        miso_drv = 1'b0; loop_en = 1'b0; tx = '0;
        tick();
        tick();
        check("rst rx", rx, 8'h00);
        check("rst busy", busy, 1'b0);
        check("rst irq", irq, 1'b0);
        check("rst sclk", sclk, 1'b0);
        check("rst mosi", mosi, 1'b0);
        check("rst mosi_en", mosi_en, 1'b0);
        rst = 1'b0;
        tick();

        // Abort: reset lands where the 9th SCLK edge would have been.
        loop_en = 1'b1;
        tx      = 8'hA5;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 8; n++) begin
            ena = 1'b1;
            tick();
        end
        check("abort busy_mid", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ena = 1'b0;
        check("abort busy", busy, 1'b0);
        check("abort irq", irq, 1'b0);
        check("abort sclk", sclk, 1'b0);
        check("abort rx", rx, 8'h00);
        $display("xfer abort busy=%0b irq=%0b rx=%02h", busy, irq, rx);
        tick();

        // Mode 0 MSB first loopback, ack coincident with completion.
        run_xfer("mode0_a5", 8'hA5, 1'b0, 1'b0, 1'b0, 1, 1'b1, 8'h00, 8'hA5, 8'hA5, -1, -1, 1'b1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("mode0_a5 irq_acked", irq, 1'b0);

        // Mode 3 LSB first, tick every 4th cycle, slave returns 0x81.
        run_xfer("mode3_3c", 8'h3C, 1'b1, 1'b1, 1'b1, 4, 1'b0, 8'h81, 8'h3C, 8'h81, -1, -1, 1'b0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("mode3_3c irq_acked", irq, 1'b0);

        // Restart strobe with 0xFF mid-transfer must be ignored.
        run_xfer("restart_00", 8'h00, 1'b0, 1'b0, 1'b0, 1, 1'b1, 8'h00, 8'h00, 8'h00, 5, -1, 1'b0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        for (int n = 0; n < 10; n++) begin
            ena = n[0];
            tick();
        end
        ena = 1'b0;
        check("restart_00 busy_after", busy, 1'b0);
        check("restart_00 irq_after", irq, 1'b0);
        check("restart_00 sclk_idle", sclk, 1'b0);

        // CPOL flipped mid-transfer: waveform keeps the latched polarity until idle.
        run_xfer("cpolflip_5a", 8'h5A, 1'b0, 1'b0, 1'b0, 1, 1'b1, 8'h00, 8'h5A, 8'h5A, 3, 3, 1'b0);
        tick();
        check("cpolflip_5a sclk_new_idle", sclk, 1'b1);
        check("cpolflip_5a rx_hold", rx, 8'h5A);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
